// File: rtl/axi_read_arbiter.sv
// Arbitrates three AXI3 read masters (icache=0, dcache=1, uncached=2) onto one shared read port.
// Optional: define AXI_RD_ARB_ROUND_ROBIN_EN for round-robin instead of fixed priority 2 > 1 > 0.
module axi_read_arbiter #(
  parameter int BUS_WIDTH = 4
) (
  input  logic                   aclk,
  input  logic                   reset,
  input  logic [2:0]             m_arvalid,
  output logic [2:0]             m_arready,
  input  logic [3*BUS_WIDTH-1:0] m_arid,
  input  logic [95:0]            m_araddr,
  input  logic [11:0]            m_arlen,
  input  logic [8:0]             m_arsize,
  input  logic [5:0]             m_arburst,
  output logic [BUS_WIDTH-1:0]   m_rid,
  output logic [31:0]            m_rdata,
  output logic [1:0]             m_rresp,
  output logic                   m_rlast,
  output logic [2:0]             m_rvalid,
  input  logic [2:0]             m_rready,
  output logic [BUS_WIDTH-1:0]   s_arid,
  output logic [31:0]            s_araddr,
  output logic [3:0]             s_arlen,
  output logic [2:0]             s_arsize,
  output logic [1:0]             s_arburst,
  output logic                   s_arvalid,
  input  logic                   s_arready,
  input  logic [BUS_WIDTH-1:0]   s_rid,
  input  logic [31:0]            s_rdata,
  input  logic [1:0]             s_rresp,
  input  logic                   s_rlast,
  input  logic                   s_rvalid,
  output logic                   s_rready,
  output logic [2:0]             grant
);

  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_e;

  state_e               state_q, state_d;
  logic [2:0]           grant_q, grant_d;
  logic                 s_arvalid_q, s_arvalid_d;
  logic [BUS_WIDTH-1:0] s_arid_q, s_arid_d;
  logic [31:0]          s_araddr_q, s_araddr_d;
  logic [3:0]           s_arlen_q, s_arlen_d;
  logic [2:0]           s_arsize_q, s_arsize_d;
  logic [1:0]           s_arburst_q, s_arburst_d;

  logic [1:0] win_idx;
  logic [1:0] gnt_idx;

`ifdef AXI_RD_ARB_ROUND_ROBIN_EN
  logic [1:0] last_grant_q, last_grant_d;
  logic [1:0] ord0, ord1, ord2;

  // Search order starts just after the previous winner and wraps 2 -> 0.
  always_comb begin
    case (last_grant_q)
      2'd0:    begin ord0 = 2'd1; ord1 = 2'd2; ord2 = 2'd0; end
      2'd1:    begin ord0 = 2'd2; ord1 = 2'd0; ord2 = 2'd1; end
      default: begin ord0 = 2'd0; ord1 = 2'd1; ord2 = 2'd2; end
    endcase
    if (m_arvalid[ord0])      win_idx = ord0;
    else if (m_arvalid[ord1]) win_idx = ord1;
    else                      win_idx = ord2;
  end
`else
  always_comb begin
    if (m_arvalid[2])      win_idx = 2'd2;
    else if (m_arvalid[1]) win_idx = 2'd1;
    else                   win_idx = 2'd0;
  end
`endif

  assign gnt_idx = grant_q[2] ? 2'd2 : (grant_q[1] ? 2'd1 : 2'd0);

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    state_d     = state_q;
    grant_d     = grant_q;
    s_arvalid_d = s_arvalid_q;
    s_arid_d    = s_arid_q;
    s_araddr_d  = s_araddr_q;
    s_arlen_d   = s_arlen_q;
    s_arsize_d  = s_arsize_q;
    s_arburst_d = s_arburst_q;
`ifdef AXI_RD_ARB_ROUND_ROBIN_EN
    last_grant_d = last_grant_q;
`endif
    m_arready   = 3'b000;
    m_rvalid    = 3'b000;
    s_rready    = 1'b0;

    case (state_q)
      IDLE: begin
        // The AR handshake with the master happens here; the slave sees it a cycle later.
        if ((|m_arvalid) && !reset) begin
          m_arready   = 3'b001 << win_idx;
          grant_d     = 3'b001 << win_idx;
          s_arid_d    = m_arid[int'(win_idx)*BUS_WIDTH +: BUS_WIDTH];
          s_araddr_d  = m_araddr[int'(win_idx)*32 +: 32];
          s_arlen_d   = m_arlen[int'(win_idx)*4 +: 4];
          s_arsize_d  = m_arsize[int'(win_idx)*3 +: 3];
          s_arburst_d = m_arburst[int'(win_idx)*2 +: 2];
          s_arvalid_d = 1'b1;
          state_d     = ADDR;
`ifdef AXI_RD_ARB_ROUND_ROBIN_EN
          last_grant_d = win_idx;
`endif
        end
      end
      ADDR: begin
        if (s_arready) begin
          s_arvalid_d = 1'b0;
          state_d     = DATA;
        end
      end
      DATA: begin
        m_rvalid[gnt_idx] = s_rvalid;
        s_rready          = m_rready[gnt_idx];
        if (s_rvalid && m_rready[gnt_idx] && s_rlast) begin
          grant_d = 3'b000;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
    if (reset) begin
      state_q     <= IDLE;
      grant_q     <= 3'b000;
      s_arvalid_q <= 1'b0;
      s_arid_q    <= '0;
      s_araddr_q  <= '0;
      s_arlen_q   <= '0;
      s_arsize_q  <= '0;
      s_arburst_q <= '0;
`ifdef AXI_RD_ARB_ROUND_ROBIN_EN
      last_grant_q <= 2'd0;
`endif
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      s_arvalid_q <= s_arvalid_d;
      s_arid_q    <= s_arid_d;
      s_araddr_q  <= s_araddr_d;
      s_arlen_q   <= s_arlen_d;
      s_arsize_q  <= s_arsize_d;
      s_arburst_q <= s_arburst_d;
`ifdef AXI_RD_ARB_ROUND_ROBIN_EN
      last_grant_q <= last_grant_d;
`endif
    end
  end

  assign grant     = grant_q;
  assign s_arvalid = s_arvalid_q;
  assign s_arid    = s_arid_q;
  assign s_araddr  = s_araddr_q;
  assign s_arlen   = s_arlen_q;
  assign s_arsize  = s_arsize_q;
  assign s_arburst = s_arburst_q;

  assign m_rid   = s_rid;
  assign m_rdata = s_rdata;
  assign m_rresp = s_rresp;
  assign m_rlast = s_rlast;

endmodule

// File: tb/tb_axi_read_arbiter.sv
// Randomized bench for axi_read_arbiter: transaction-level model of masters, slave and arbitration.
// Define AXI_RD_ARB_ROUND_ROBIN_EN here as well as in the RTL to check the round-robin build.
module tb_axi_read_arbiter;
  localparam int BW = 4;

  logic          aclk = 1'b0;
  logic          reset;
  logic [2:0]    m_arvalid, m_arready;
  logic [3*BW-1:0] m_arid;
  logic [95:0]   m_araddr;
  logic [11:0]   m_arlen;
  logic [8:0]    m_arsize;
  logic [5:0]    m_arburst;
  logic [BW-1:0] m_rid;
  logic [31:0]   m_rdata;
  logic [1:0]    m_rresp;
  logic          m_rlast;
  logic [2:0]    m_rvalid, m_rready;
  logic [BW-1:0] s_arid;
  logic [31:0]   s_araddr;
  logic [3:0]    s_arlen;
  logic [2:0]    s_arsize;
  logic [1:0]    s_arburst;
  logic          s_arvalid, s_arready;
  logic [BW-1:0] s_rid;
  logic [31:0]   s_rdata;
  logic [1:0]    s_rresp;
  logic          s_rlast, s_rvalid, s_rready;
  logic [2:0]    grant;

  always #5 aclk = ~aclk;

  axi_read_arbiter #(.BUS_WIDTH(BW)) dut (
    .aclk(aclk), .reset(reset),
    .m_arvalid(m_arvalid), .m_arready(m_arready), .m_arid(m_arid), .m_araddr(m_araddr),
    .m_arlen(m_arlen), .m_arsize(m_arsize), .m_arburst(m_arburst),
    .m_rid(m_rid), .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rlast(m_rlast),
    .m_rvalid(m_rvalid), .m_rready(m_rready),
    .s_arid(s_arid), .s_araddr(s_araddr), .s_arlen(s_arlen), .s_arsize(s_arsize),
    .s_arburst(s_arburst), .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rid(s_rid), .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rlast(s_rlast),
    .s_rvalid(s_rvalid), .s_rready(s_rready), .grant(grant)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Master-side request state
  logic [2:0]    req;
  logic [31:0]   r_addr  [3];
  logic [BW-1:0] r_id    [3];
  logic [3:0]    r_len   [3];
  logic [2:0]    r_size  [3];
  logic [1:0]    r_burst [3];

  // Model of the shared port: 0 = no burst, 1 = address pending, 2 = data returning
  int            phase, owner, last_rr, beats_left;
  logic [31:0]   p_addr;
  logic [BW-1:0] p_id;
  logic [3:0]    p_len;
  logic [2:0]    p_size;
  logic [1:0]    p_burst;
  int            grants_seen[$];

  function automatic int pick(input logic [2:0] v, input int last);
`ifdef AXI_RD_ARB_ROUND_ROBIN_EN
    for (int k = 1; k <= 3; k++) begin
      int c;
      c = (last + k) % 3;
      if (v[c]) return c;
    end
    return 0;
`else
    for (int c = 2; c >= 0; c--) if (v[c]) return c;
    return 0;
`endif
  endfunction

  task automatic new_req(input int i);
    req[i]     = 1'b1;
    r_addr[i]  = $urandom;
    r_id[i]    = BW'($urandom);
    r_len[i]   = 4'($urandom_range(0, 15));
    r_size[i]  = 3'($urandom_range(0, 2));
    r_burst[i] = 2'($urandom_range(0, 2));
  endtask

  task automatic drive_masters();
    for (int i = 0; i < 3; i++) begin
      m_arvalid[i]          = req[i];
      m_araddr[i*32 +: 32]  = r_addr[i];
      m_arid[i*BW +: BW]    = r_id[i];
      m_arlen[i*4 +: 4]     = r_len[i];
      m_arsize[i*3 +: 3]    = r_size[i];
      m_arburst[i*2 +: 2]   = r_burst[i];
    end
  endtask

  initial begin
    logic [2:0] exp_arready, exp_grant, exp_rvalid, hs_ar;
    logic       exp_sarvalid, exp_srready, r_hs, was_reset, reset_done;
    int         w;
    int         exp_order[3];

`ifdef AXI_RD_ARB_ROUND_ROBIN_EN
    exp_order = '{1, 2, 0};
`else
    exp_order = '{2, 1, 0};
`endif

    reset = 1'b1;
    req = 3'b000;
    for (int i = 0; i < 3; i++) begin
      r_addr[i] = '0; r_id[i] = '0; r_len[i] = '0; r_size[i] = '0; r_burst[i] = '0;
    end
    drive_masters();
    m_rready = 3'b000;
    s_arready = 1'b0;
    s_rid = '0; s_rdata = '0; s_rresp = '0; s_rlast = 1'b0; s_rvalid = 1'b0;
    phase = 0; owner = 0; last_rr = 0; beats_left = 0;
    p_addr = '0; p_id = '0; p_len = '0; p_size = '0; p_burst = '0;
    was_reset = 1'b1;
    reset_done = 1'b0;

    repeat (2) @(posedge aclk);
    #1;
    reset = 1'b0;
    // All three masters request together; icache carries the boot-vector read.
    for (int i = 0; i < 3; i++) new_req(i);
    r_addr[0] = 32'h1FC0_0000;
    r_len[0]  = 4'd7;
    drive_masters();

    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(negedge aclk);
      hs_ar = 3'b000;
      r_hs  = 1'b0;
      if (!reset) begin
        exp_arready  = 3'b000;
        exp_grant    = 3'b000;
        exp_rvalid   = 3'b000;
        exp_sarvalid = 1'b0;
        exp_srready  = 1'b0;
        w = 0;
        if (was_reset) begin
          check("reset_ar_payload", {s_arid, s_araddr, s_arlen, s_arsize, s_arburst}, 64'd0);
          was_reset = 1'b0;
        end
        case (phase)
          0: if (|m_arvalid) begin
               w = pick(m_arvalid, last_rr);
               exp_arready[w] = 1'b1;
             end
          1: begin
               exp_grant[owner] = 1'b1;
               exp_sarvalid = 1'b1;
             end
          default: begin
               exp_grant[owner]  = 1'b1;
               exp_rvalid[owner] = s_rvalid;
               exp_srready       = m_rready[owner];
             end
        endcase
        check("m_arready", m_arready, exp_arready);
        check("grant", grant, exp_grant);
        check("s_arvalid", s_arvalid, exp_sarvalid);
        check("m_rvalid", m_rvalid, exp_rvalid);
        check("s_rready", s_rready, exp_srready);
        if (phase == 1)
          check("s_ar_payload", {s_arid, s_araddr, s_arlen, s_arsize, s_arburst},
                {p_id, p_addr, p_len, p_size, p_burst});
        if (phase == 2)
          check("r_broadcast", {m_rid, m_rdata, m_rresp, m_rlast}, {s_rid, s_rdata, s_rresp, s_rlast});

        case (phase)
          0: if (|m_arvalid) begin
               owner = w; last_rr = w; hs_ar[w] = 1'b1;
               p_addr = r_addr[w]; p_id = r_id[w]; p_len = r_len[w];
               p_size = r_size[w]; p_burst = r_burst[w];
               beats_left = int'(p_len) + 1;
               if (grants_seen.size() < 3)
                 check("initial_grant_order", 64'(w), 64'(exp_order[grants_seen.size()]));
               grants_seen.push_back(w);
               phase = 1;
             end
          1: if (s_arready) phase = 2;
          default: if (s_rvalid && m_rready[owner]) begin
               r_hs = 1'b1;
               beats_left--;
               if (s_rlast) phase = 0;
             end
        endcase
      end

      @(posedge aclk);
      #1;
      if (reset) begin
        // Both sides reset together: masters drop requests, slave drops its burst.
        reset = 1'b0;
        req = 3'b000;
        phase = 0; last_rr = 0; beats_left = 0;
        s_rvalid = 1'b0;
        s_rlast = 1'b0;
        was_reset = 1'b1;
      end else begin
        req = req & ~hs_ar;
        if (grants_seen.size() >= 3)
          for (int i = 0; i < 3; i++)
            if (!req[i] && $urandom_range(0, 3) == 0) new_req(i);
        s_arready = 1'($urandom_range(0, 1));
        if (r_hs) s_rvalid = 1'b0;
        if (phase == 2 && beats_left > 0) begin
          if (!s_rvalid && $urandom_range(0, 2) != 0) begin
            s_rvalid = 1'b1;
            s_rdata  = $urandom;
            s_rresp  = 2'($urandom_range(0, 3));
            s_rid    = p_id;
            s_rlast  = (beats_left == 1);
          end
        end else begin
          s_rvalid = 1'b0;
        end
        m_rready = 3'($urandom_range(0, 7));
        if (!reset_done && phase == 2 &&
            ((cyc > 1500 && p_len == 4'd7 && beats_left == 7) || cyc > 3500)) begin
          reset = 1'b1;
          reset_done = 1'b1;
        end
      end
      drive_masters();
    end

    check("reset_mid_burst_applied", 64'(reset_done), 64'd1);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/axi_read_arbiter.md
Name: axi_read_arbiter

Overview:
- Arbitrates the read channels (AR/R) of the three CPU-side AXI3 masters onto one shared AXI3 read port toward the SoC interconnect.
- The three masters are icache (index 0), dcache (index 1) and uncached (index 2).
- Supports one outstanding read burst at a time. A grant is held from AR issue until the R beat with rlast completes.
- Write channels bypass this block.

Parameters:
BUS_WIDTH, 4, AXI ID width per master and on the shared port

Ports:
aclk  input  1  clock, rising edge
reset  input  1  synchronous, active-high reset
m_arvalid  input  3  per-master AR valid, bit i = master i
m_arready  output  3  per-master AR ready
m_arid  input  3*BUS_WIDTH  per-master ARID, master i at [i*BUS_WIDTH +: BUS_WIDTH]
m_araddr  input  96  per-master ARADDR, master i at [i*32 +: 32]
m_arlen  input  12  per-master ARLEN, 4 bits each
m_arsize  input  9  per-master ARSIZE, 3 bits each
m_arburst  input  6  per-master ARBURST, 2 bits each
m_rid  output  BUS_WIDTH  RID broadcast to all masters
m_rdata  output  32  RDATA broadcast
m_rresp  output  2  RRESP broadcast
m_rlast  output  1  RLAST broadcast
m_rvalid  output  3  per-master RVALID, only the granted bit may be 1
m_rready  input  3  per-master RREADY
s_arid  output  BUS_WIDTH  shared ARID
s_araddr  output  32  shared ARADDR
s_arlen  output  4  shared ARLEN
s_arsize  output  3  shared ARSIZE
s_arburst  output  2  shared ARBURST
s_arvalid  output  1  shared ARVALID
s_arready  input  1  shared ARREADY
s_rid  input  BUS_WIDTH  shared RID
s_rdata  input  32  shared RDATA
s_rresp  input  2  shared RRESP
s_rlast  input  1  shared RLAST
s_rvalid  input  1  shared RVALID
s_rready  output  1  shared RREADY
grant  output  3  one-hot current owner, 0 when idle

Behaviour:
- Clocking and reset: one clock, aclk; reset is synchronous and active-high.
- Reset values: state=IDLE, grant=0, s_arvalid=0, s_araddr/s_arid/s_arlen/s_arsize/s_arburst=0, m_arready=0, m_rvalid=0, s_rready=0.
- FSM states: IDLE, ADDR, DATA.
- IDLE:
  - If any m_arvalid bit is set, pick a winner (fixed priority 2 > 1 > 0, default build) and register grant.
  - Register the winner's AR payload into the s_ar* registers, then go to ADDR.
  - Winner's m_arready pulses high for exactly that cycle; this is the AR handshake with the master.
  - With no request, stay in IDLE.
- ADDR:
  - s_arvalid=1 with the registered payload, held stable until s_arready.
  - On s_arvalid&s_arready, go to DATA with s_arvalid=0 registered.
  - First s_arvalid is one cycle after the master's AR handshake.
- DATA:
  - Combinational pass-through: m_rvalid[g]=s_rvalid, s_rready=m_rready[g], m_rid/m_rdata/m_rresp/m_rlast=s_r* (g = granted index).
  - Non-granted m_rvalid bits are 0. s_rready=0 outside DATA.
  - On s_rvalid&s_rready&s_rlast, go to IDLE and clear grant.
- Re-arbitration: the earliest next grant is the cycle after returning to IDLE (one bubble). No back-to-back overlap.
- Simultaneous requests are resolved by priority only. Losers keep m_arvalid asserted, per AXI, and are served later.
- A request arriving in the same cycle as rlast is not considered until IDLE.
- Reset mid-burst: all outputs return to reset values next edge; remaining R beats from the slave are dropped (s_rready=0). The system resets both sides together.
- m_arready is never high outside IDLE. At most one m_arready bit is high per cycle.
- Width rules: no arithmetic; fields are sliced as listed; arlen is passed unchanged (max 16 beats).

Optional Feature:
- Macro: AXI_RD_ARB_ROUND_ROBIN_EN.
- Defined:
  - Round-robin arbitration; a 2-bit last_grant register (reset 0) is updated on each grant.
  - The search starts at (last_grant+1) mod 3 and wraps 2→0.
- Undefined: fixed priority 2 > 1 > 0 and no last_grant register.

Test Plan:
- Single icache read, araddr=0x1FC00000, arlen=7: m_arready[0] pulses once; s_arvalid next cycle with the same payload; 8 beats routed only to m_rvalid[0]; grant returns to 0 after rlast.
- All three masters request in the same cycle (fixed priority): grant order is 3'b100, 3'b010, 3'b001, with one IDLE bubble between bursts.
- Same as above with AXI_RD_ARB_ROUND_ROBIN_EN after reset: order is 1, 2, 0. After a master-1 grant with masters 0 and 1 both re-requesting, master 0 wins.
- s_arready held low for 5 cycles: s_arvalid and payload stay stable for 5 cycles; no m_arready to any other master.
- Backpressure, dcache arlen=3, m_rready[1] toggling 1,0,1,0: s_rready mirrors it; beats are counted only on handshake; FSM leaves DATA only on the 4th beat with rlast.
- Assert reset during beat 2 of an 8-beat burst: next cycle grant=0, s_rready=0, m_rvalid=0, state=IDLE.
